uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, 8, byte width of every data path.
REQ-002 Parameter: IDLE_TIMEOUT, 1024, number of consecutive stall cycles (valid low while granted) after which a grant is revoked.
REQ-003 Port: clock  input  1  single clock for all state.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: req0_data  input  DATA_WIDTH  requester 0 byte.
REQ-006 Port: req0_valid  input  1  requester 0 byte available.
REQ-007 Port: req0_last  input  1  requester 0 byte is the final byte of its packet.
REQ-008 Port: req0_ready  output  1  requester 0 byte accepted this cycle.
REQ-009 Port: req1_data / req1_valid / req1_last / req1_ready; same widths, directions and meanings as requester 0.
REQ-010 Port: tx_data  output  DATA_WIDTH  byte to the shared UART transmitter.
REQ-011 Port: tx_valid  output  1  tx_data valid.
REQ-012 Port: tx_ready  input  1  UART transmitter accepts a byte.
REQ-013 Port: grant  output  2  one-hot current owner (bit0 = req0, bit1 = req1), 00 when idle.
REQ-014 Port: timeout_pulse  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-015 States SHALL be IDLE, GRANT0 and GRANT1; grant SHALL equal 00, 01 and 10 respectively.
REQ-016 Transfer definition: a byte transfers on a rising edge where tx_valid and tx_ready are both high.
REQ-017 IDLE: tx_valid = 0, both readies = 0, no transfer.
REQ-018 IDLE -> GRANTn on the next edge when only reqn_valid is high.
REQ-019 IDLE with both valid high: grant the requester selected by the priority pointer.
REQ-020 Priority pointer: reset value 0, selects req0.
REQ-021 GRANTn datapath: tx_data = reqn_data and tx_valid = reqn_valid, combinational, zero latency.
REQ-022 GRANTn handshake: reqn_ready = tx_ready; the non-granted ready = 0; non-granted inputs SHALL NOT affect any output.
REQ-023 GRANTn SHALL persist across multi-byte packets, including while reqn_valid is low, until release.
REQ-024 Release by last: a transfer with reqn_last = 1 returns to IDLE on that edge, and the priority pointer is set to the other requester.
REQ-025 Stall counter: clears on entering GRANTn and on every transfer; increments each GRANTn cycle with reqn_valid = 0; saturates at IDLE_TIMEOUT.
REQ-026 Release by timeout: when the stall counter reaches IDLE_TIMEOUT-1 and reqn_valid = 0, the next edge returns to IDLE, asserts timeout_pulse for exactly one cycle, and sets the priority pointer to the other requester.
REQ-027 Cycle with reqn_valid = 1 and tx_ready = 0 SHALL NOT count as a stall.
REQ-028 Minimum gap: at least one IDLE cycle SHALL separate consecutive grants, so back-to-back packets from the same or different requesters cost one bubble cycle.
REQ-029 Single requester: a lone requester SHALL be re-granted regardless of the priority pointer.
REQ-030 Counter width: clog2(IDLE_TIMEOUT)+1 bits; no wrap-around is permitted.

Reset
REQ-031 Asserting reset low SHALL immediately (asynchronously) force IDLE, grant = 00, tx_valid = 0, req0_ready = req1_ready = 0, timeout_pulse = 0, stall counter = 0 and priority pointer = 0.
REQ-032 Reset mid-packet SHALL abandon the packet; after release, arbitration restarts from IDLE on the first edge.
REQ-033 Reset deassertion SHALL be treated as synchronous to clock by the surrounding design; the block adds no synchronizer.

Verification
REQ-034 Scenario: both valid from reset; req0 sends 3 bytes (0x41, 0x42, 0x43 last), req1 sends 0x61 last, tx_ready = 1 -> tx sequence is 41 42 43 then 61, grant goes 01, 00, 10, 00, with one bubble cycle between packets.
REQ-035 Scenario: tx_ready held low 50 cycles during req0 packet with valid high -> no timeout, tx_data stable, req0_ready = 0 throughout.
REQ-036 Scenario: IDLE_TIMEOUT = 16; req0 granted, sends 0x10 (not last), then drops valid -> 16 stall cycles later grant = 00, timeout_pulse high for 1 cycle, and req1 (waiting) is granted on the following edge.
REQ-037 Scenario: req1 only, two single-byte packets 0x01 and 0x02 -> both granted to req1 despite the pointer, each followed by an IDLE cycle.
REQ-038 Scenario: reset asserted mid-packet in GRANT1 between clock edges -> all outputs reach their reset values without a clock edge; after release with both valid, req0 is granted first.
REQ-039 Scenario: req1 toggles valid, data and last randomly while req0 is granted -> tx_* and req0_ready are unaffected, and req1_ready stays 0.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester, transmitter and status signals of the two-requester UART TX arbiter.
// The master modport is the system side (requesters plus UART); the slave modport is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_valid;
  logic                  req0_last;
  logic                  req0_ready;

  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_valid;
  logic                  req1_last;
  logic                  req1_ready;

  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  logic [1:0]            grant;
  logic                  timeout_pulse;

  modport master (
    output req0_data, req0_valid, req0_last,
    output req1_data, req1_valid, req1_last,
    output tx_ready,
    input  req0_ready, req1_ready,
    input  tx_data, tx_valid,
    input  grant, timeout_pulse
  );

  modport slave (
    input  req0_data, req0_valid, req0_last,
    input  req1_data, req1_valid, req1_last,
    input  tx_ready,
    output req0_ready, req1_ready,
    output tx_data, tx_valid,
    output grant, timeout_pulse
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-level arbiter sharing one UART transmitter between two byte-stream requesters.
// A grant is held for a whole packet (until a transfer flagged last) or revoked after
// IDLE_TIMEOUT consecutive cycles in which the owner presents no byte. Every release
// passes through one IDLE cycle and hands priority to the other requester.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int IDLE_TIMEOUT = 1024
) (
  input logic              clock,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(IDLE_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] STALL_MAX  = CNT_W'(IDLE_TIMEOUT);
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t                state;
  logic [1:0]            grant_q;
  logic                  timeout_q;
  logic                  prio;        // 0: req0 wins a tie, 1: req1 wins a tie
  logic [CNT_W-1:0]      stall_cnt;

  logic [DATA_WIDTH-1:0] tx_data_c;
  logic                  tx_valid_c;
  logic                  req0_ready_c;
  logic                  req1_ready_c;
  logic                  sel_last_c;
  logic                  xfer;

  // Saturating increment so the stall counter can never wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] nxt;
    nxt = (cnt >= STALL_MAX) ? cnt : cnt + CNT_W'(1);
    return nxt;
  endfunction

  // Zero-latency routing of the granted requester; the other requester is fully masked.
  always_comb begin
    tx_data_c    = '0;
    tx_valid_c   = 1'b0;
    req0_ready_c = 1'b0;
    req1_ready_c = 1'b0;
    sel_last_c   = 1'b0;
    case (state)
      GRANT0: begin
        tx_data_c    = bus.req0_data;
        tx_valid_c   = bus.req0_valid;
        req0_ready_c = bus.tx_ready;
        sel_last_c   = bus.req0_last;
      end
      GRANT1: begin
        tx_data_c    = bus.req1_data;
        tx_valid_c   = bus.req1_valid;
        req1_ready_c = bus.tx_ready;
        sel_last_c   = bus.req1_last;
      end
      default: begin
        tx_data_c = '0;
      end
    endcase
  end

  assign xfer = tx_valid_c & bus.tx_ready;

  // Arbitration FSM: grant selection, packet/timeout release, stall tracking, priority flip.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      grant_q   <= 2'b00;
      timeout_q <= 1'b0;
      prio      <= 1'b0;
      stall_cnt <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          stall_cnt <= '0;
          if (bus.req0_valid && (!bus.req1_valid || !prio)) begin
            state   <= GRANT0;
            grant_q <= 2'b01;
          end else if (bus.req1_valid) begin
            state   <= GRANT1;
            grant_q <= 2'b10;
          end
        end
        GRANT0, GRANT1: begin
          if (xfer) begin
            stall_cnt <= '0;
            if (sel_last_c) begin
              state   <= IDLE;
              grant_q <= 2'b00;
              prio    <= (state == GRANT0);
            end
          end else if (!tx_valid_c) begin
            // Only an absent byte is a stall; a byte held off by tx_ready is not.
            if (stall_cnt == STALL_LAST) begin
              state     <= IDLE;
              grant_q   <= 2'b00;
              timeout_q <= 1'b1;
              prio      <= (state == GRANT0);
              stall_cnt <= '0;
            end else begin
              stall_cnt <= sat_inc(stall_cnt);
            end
          end
        end
        default: begin
          state     <= IDLE;
          grant_q   <= 2'b00;
          stall_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.tx_data       = tx_data_c;
  assign bus.tx_valid      = tx_valid_c;
  assign bus.req0_ready    = req0_ready_c;
  assign bus.req1_ready    = req1_ready_c;
  assign bus.grant         = grant_q;
  assign bus.timeout_pulse = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte queues feed the DUT, a packet-level
// arbitration model fills the expected-transfer queue, and a negedge monitor checks
// every transfer and the routing of the granted requester.
module tb_uart_tx_arbiter;
  localparam int DW = 8;
  localparam int TO = 16;

  typedef struct { logic [7:0] data; logic last; int gap; } byte_t;
  typedef struct { logic [7:0] data; int src; } xfer_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.DATA_WIDTH(DW)) bus();

  uart_tx_arbiter #(.DATA_WIDTH(DW), .IDLE_TIMEOUT(TO)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int    checks    = 0;
  int    errors    = 0;
  int    pulse_cnt = 0;
  byte_t q0[$];
  byte_t q1[$];
  byte_t m0[$];
  byte_t m1[$];
  xfer_t exp_q[$];
  xfer_t mon_e;
  bit    noise1 = 1'b0;
  bit    f0, f1;

  logic [1:0] g34 [6] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00};
  logic [1:0] g37 [4] = '{2'b10, 2'b00, 2'b10, 2'b00};
  logic [1:0] g38 [4] = '{2'b01, 2'b00, 2'b10, 2'b10};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_grant"}, 32'(bus.grant), 32'd0);
    check({name, "_outs"},
          32'({bus.tx_valid, bus.req0_ready, bus.req1_ready, bus.timeout_pulse}), 32'd0);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.tx_ready  = 1'b0;
    noise1        = 1'b0;
    q0.delete();
    q1.delete();
    exp_q.delete();
    #1;
    check_reset_outputs("reset");
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Requester 0 driver: presents the queue head, honours per-byte gaps, pops on transfer.
  initial begin : drv0
    bus.req0_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req0_last  = 1'b0;
    forever begin
      @(negedge clk);
      f0 = bus.req0_valid && bus.req0_ready;
      @(posedge clk);
      #2;
      if (f0 && q0.size() > 0) void'(q0.pop_front());
      if (q0.size() > 0 && q0[0].gap > 0) begin
        q0[0].gap      = q0[0].gap - 1;
        bus.req0_valid = 1'b0;
        bus.req0_data  = 8'($urandom);
        bus.req0_last  = 1'($urandom);
      end else if (q0.size() > 0) begin
        bus.req0_valid = 1'b1;
        bus.req0_data  = q0[0].data;
        bus.req0_last  = q0[0].last;
      end else begin
        bus.req0_valid = 1'b0;
        bus.req0_data  = 8'($urandom);
        bus.req0_last  = 1'($urandom);
      end
    end
  end

  // Requester 1 driver: same as requester 0, plus random noise when idle and noise1 is set.
  initial begin : drv1
    bus.req1_valid = 1'b0;
    bus.req1_data  = '0;
    bus.req1_last  = 1'b0;
    forever begin
      @(negedge clk);
      f1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk);
      #2;
      if (f1 && q1.size() > 0) void'(q1.pop_front());
      if (q1.size() > 0 && q1[0].gap > 0) begin
        q1[0].gap      = q1[0].gap - 1;
        bus.req1_valid = 1'b0;
        bus.req1_data  = 8'($urandom);
        bus.req1_last  = 1'($urandom);
      end else if (q1.size() > 0) begin
        bus.req1_valid = 1'b1;
        bus.req1_data  = q1[0].data;
        bus.req1_last  = q1[0].last;
      end else begin
        bus.req1_valid = noise1 ? 1'($urandom) : 1'b0;
        bus.req1_data  = 8'($urandom);
        bus.req1_last  = 1'($urandom);
      end
    end
  end

  // Monitor: routing of the granted requester every cycle, scoreboard pop on each transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.timeout_pulse) pulse_cnt++;
      case (bus.grant)
        2'b00: check("idle_outputs",
                     32'({bus.tx_valid, bus.req0_ready, bus.req1_ready}), 32'd0);
        2'b01: begin
          check("route0", 32'({bus.tx_valid, bus.req0_ready, bus.req1_ready}),
                32'({bus.req0_valid, bus.tx_ready, 1'b0}));
          if (bus.tx_valid) check("route0_data", 32'(bus.tx_data), 32'(bus.req0_data));
        end
        2'b10: begin
          check("route1", 32'({bus.tx_valid, bus.req0_ready, bus.req1_ready}),
                32'({bus.req1_valid, 1'b0, bus.tx_ready}));
          if (bus.tx_valid) check("route1_data", 32'(bus.tx_data), 32'(bus.req1_data));
        end
        default: begin
          checks++;
          errors++;
          $display("FAIL grant_onehot: got %b, expected 00, 01 or 10", bus.grant);
        end
      endcase
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: got 0x%0h from grant %b, expected none",
                   bus.tx_data, bus.grant);
        end else begin
          mon_e = exp_q.pop_front();
          check("xfer_data", 32'(bus.tx_data), 32'(mon_e.data));
          check("xfer_src", 32'(bus.grant), (mon_e.src == 0) ? 32'd1 : 32'd2);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int    n, ptr, pick, len, p_before;
    byte_t bt, mb;

    bus.tx_ready = 1'b0;

    // Two packets, both valid from reset: req0 first, one bubble, then req1.
    do_reset();
    q0.push_back('{8'h41, 1'b0, 0});
    q0.push_back('{8'h42, 1'b0, 0});
    q0.push_back('{8'h43, 1'b1, 0});
    q1.push_back('{8'h61, 1'b1, 0});
    exp_q.push_back('{8'h41, 0});
    exp_q.push_back('{8'h42, 0});
    exp_q.push_back('{8'h43, 0});
    exp_q.push_back('{8'h61, 1});
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("s34_grant", 32'(bus.grant), 32'(g34[i]));
    end
    wait_drain("s34_drain", 20);

    // tx_ready held low with valid high: no timeout, data stable.
    do_reset();
    q0.push_back('{8'h55, 1'b0, 0});
    q0.push_back('{8'h56, 1'b1, 0});
    exp_q.push_back('{8'h55, 0});
    exp_q.push_back('{8'h56, 0});
    tick();
    check("s35_grant", 32'(bus.grant), 32'd1);
    for (int i = 0; i < 50; i++) begin
      tick();
      check("s35_hold", 32'({bus.grant, bus.timeout_pulse, bus.req0_ready}), 32'({2'b01, 1'b0, 1'b0}));
      check("s35_data", 32'(bus.tx_data), 32'h55);
    end
    bus.tx_ready = 1'b1;
    wait_drain("s35_drain", 20);

    // Timeout after 16 stall cycles, then the waiting requester is granted.
    do_reset();
    p_before = pulse_cnt;
    bus.tx_ready = 1'b1;
    q0.push_back('{8'h10, 1'b0, 0});
    exp_q.push_back('{8'h10, 0});
    tick();
    check("s36_grant", 32'(bus.grant), 32'd1);
    tick();
    q1.push_back('{8'h20, 1'b1, 0});
    exp_q.push_back('{8'h20, 1});
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("s36_stall", 32'({bus.grant, bus.timeout_pulse}), 32'({2'b01, 1'b0}));
    end
    tick();
    check("s36_revoke", 32'({bus.grant, bus.timeout_pulse}), 32'({2'b00, 1'b1}));
    tick();
    check("s36_regrant", 32'({bus.grant, bus.timeout_pulse}), 32'({2'b10, 1'b0}));
    wait_drain("s36_drain", 10);
    check("s36_pulses", 32'(pulse_cnt - p_before), 32'd1);

    // Lone requester 1 re-granted although the pointer favours requester 0.
    do_reset();
    bus.tx_ready = 1'b1;
    q1.push_back('{8'h01, 1'b1, 0});
    q1.push_back('{8'h02, 1'b1, 0});
    exp_q.push_back('{8'h01, 1});
    exp_q.push_back('{8'h02, 1});
    for (int i = 0; i < 4; i++) begin
      tick();
      check("s37_grant", 32'(bus.grant), 32'(g37[i]));
    end
    wait_drain("s37_drain", 10);

    // Asynchronous reset in the middle of a GRANT1 packet; pointer returns to req0.
    do_reset();
    bus.tx_ready = 1'b1;
    q0.push_back('{8'hA0, 1'b1, 0});
    q1.push_back('{8'h71, 1'b0, 0});
    q1.push_back('{8'h72, 1'b0, 0});
    q1.push_back('{8'h73, 1'b1, 0});
    exp_q.push_back('{8'hA0, 0});
    exp_q.push_back('{8'h71, 1});
    for (int i = 0; i < 4; i++) begin
      tick();
      check("s38_grant", 32'(bus.grant), 32'(g38[i]));
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("s38_async");
    check("s38_sb_empty", 32'(exp_q.size()), 32'd0);
    q0.delete();
    q1.delete();
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    q0.push_back('{8'h81, 1'b1, 0});
    q1.push_back('{8'h91, 1'b1, 0});
    exp_q.push_back('{8'h81, 0});
    exp_q.push_back('{8'h91, 1});
    tick();
    check("s38_restart_grant", 32'(bus.grant), 32'd1);
    wait_drain("s38_drain", 10);

    // Requester 1 noise while requester 0 owns the transmitter.
    do_reset();
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bt = '{8'($urandom), (i == 9), (i == 0) ? 0 : int'($urandom_range(0, 8))};
      q0.push_back(bt);
      exp_q.push_back('{bt.data, 0});
    end
    tick();
    check("s39_grant", 32'(bus.grant), 32'd1);
    noise1 = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 2000) begin
      bus.tx_ready = 1'($urandom);
      if (q0.size() <= 2) noise1 = 1'b0;
      tick();
      n++;
    end
    noise1 = 1'b0;
    check("s39_drain", 32'(exp_q.size()), 32'd0);
    tick();
    tick();
    check("s39_no_grant1", 32'(bus.grant), 32'd0);

    // Randomised packets from both requesters against the packet-level arbitration model.
    do_reset();
    p_before = pulse_cnt;
    m0.delete();
    m1.delete();
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 10; p++) begin
        len = int'($urandom_range(1, 5));
        for (int b = 0; b < len; b++) begin
          bt = '{8'($urandom), (b == len - 1), (b == 0) ? 0 : int'($urandom_range(0, 6))};
          if (r == 0) begin
            q0.push_back(bt);
            m0.push_back(bt);
          end else begin
            q1.push_back(bt);
            m1.push_back(bt);
          end
        end
      end
    end
    ptr = 0;
    while (m0.size() > 0 || m1.size() > 0) begin
      if (m0.size() > 0 && m1.size() > 0) pick = ptr;
      else pick = (m0.size() > 0) ? 0 : 1;
      do begin
        if (pick == 0) mb = m0.pop_front();
        else mb = m1.pop_front();
        exp_q.push_back('{mb.data, pick});
      end while (!mb.last);
      ptr = 1 - pick;
    end
    n = 0;
    while (exp_q.size() > 0 && n < 6000) begin
      bus.tx_ready = 1'($urandom);
      tick();
      n++;
    end
    check("rand_drain", 32'(exp_q.size()), 32'd0);
    check("rand_no_timeout", 32'(pulse_cnt - p_before), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
